// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX operand forwarding, ID load-use detection and a one-entry
// multiplier scoreboard (IDLE/BUSY/DONE) with a latency counter and ID result bypass.
// Optional macro HAZARD_ZERO_REG_EN: address 0 never matches any compare.
module hazard_fwd_unit #(
  parameter int AW      = 3,
  parameter int MUL_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic [AW-1:0] id_dest,
  input  logic          id_reg_write,
  input  logic          id_is_mul,
  input  logic          branch_flush,
  input  logic [AW-1:0] ex_rs1,
  input  logic [AW-1:0] ex_rs2,
  input  logic [AW-1:0] ex_dest,
  input  logic          ex_reg_write,
  input  logic          ex_is_load,
  input  logic [AW-1:0] mem_dest,
  input  logic          mem_reg_write,
  input  logic [AW-1:0] wb_dest,
  input  logic          wb_reg_write,
  output logic [1:0]    fwd_a_sel,
  output logic [1:0]    fwd_b_sel,
  output logic          stall,
  output logic          id_ex_bubble,
  output logic          mul_busy,
  output logic          mul_done,
  output logic [AW-1:0] mul_dest,
  output logic          id_byp_a,
  output logic          id_byp_b
);

  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pend_q, pend_d;

  logic ld_haz;
  logic sb_haz;
  logic issue;

  // Register-address match; r0 can be made a never-matching hardwired zero.
  function automatic logic addr_eq(input logic [AW-1:0] a, input logic [AW-1:0] b);
`ifdef HAZARD_ZERO_REG_EN
    return (a == b) && (a != '0);
`else
    return (a == b);
`endif
  endfunction

  // Operand forwarding: youngest producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    if (mem_reg_write && addr_eq(mem_dest, ex_rs1))     fwd_a_sel = SEL_MEM;
    else if (wb_reg_write && addr_eq(wb_dest, ex_rs1))  fwd_a_sel = SEL_WB;
    if (mem_reg_write && addr_eq(mem_dest, ex_rs2))     fwd_b_sel = SEL_MEM;
    else if (wb_reg_write && addr_eq(wb_dest, ex_rs2))  fwd_b_sel = SEL_WB;
  end

  // Hazard detection: load-use against ID/EX, scoreboard only while the multiplier is busy.
  always_comb begin
    ld_haz = ex_is_load && ex_reg_write &&
             ((id_rs1_used && addr_eq(ex_dest, id_rs1)) ||
              (id_rs2_used && addr_eq(ex_dest, id_rs2)));
    sb_haz = 1'b0;
    if (state_q == S_BUSY) begin
      sb_haz = (id_rs1_used && addr_eq(id_rs1, pend_q)) ||
               (id_rs2_used && addr_eq(id_rs2, pend_q)) ||
               (id_reg_write && addr_eq(id_dest, pend_q)) ||
               id_is_mul;
    end
    stall        = ld_haz || sb_haz;
    id_ex_bubble = stall || branch_flush;
    issue        = id_is_mul && !stall && !branch_flush;
  end

  // Scoreboard next state: DONE may chain straight into BUSY for back-to-back multiplies.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_BUSY;
          cnt_d   = CNT_LOAD;
          pend_d  = id_dest;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE: begin
        if (issue) begin
          state_d = S_BUSY;
          cnt_d   = CNT_LOAD;
          pend_d  = id_dest;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scoreboard registers; reset aborts an in-flight multiply without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Status and ID-stage bypass of the multiplier result during its write-back cycle.
  always_comb begin
    mul_busy = (state_q == S_BUSY);
    mul_done = (state_q == S_DONE);
    mul_dest = pend_q;
    id_byp_a = mul_done && id_rs1_used && addr_eq(id_rs1, pend_q);
    id_byp_b = mul_done && id_rs2_used && addr_eq(id_rs2, pend_q);
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Testbench for hazard_fwd_unit: vector table for combinational paths, directed
// multiplier/reset sequences, and randomized cycles against a timeline model.
module tb_hazard_fwd_unit;
  localparam int AW = 3;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, id_dest, ex_rs1, ex_rs2, ex_dest, mem_dest, wb_dest;
  logic          id_rs1_used, id_rs2_used, id_reg_write, id_is_mul, branch_flush;
  logic          ex_reg_write, ex_is_load, mem_reg_write, wb_reg_write;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall, id_ex_bubble, mul_busy, mul_done, id_byp_a, id_byp_b;
  logic [AW-1:0] mul_dest;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.AW(AW), .MUL_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_is_mul(id_is_mul),
    .branch_flush(branch_flush), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .mem_dest(mem_dest),
    .mem_reg_write(mem_reg_write), .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .id_ex_bubble(id_ex_bubble),
    .mul_busy(mul_busy), .mul_done(mul_done), .mul_dest(mul_dest),
    .id_byp_a(id_byp_a), .id_byp_b(id_byp_b)
  );

  typedef struct {
    logic [AW-1:0] ex_rs1, ex_rs2, mem_dest, wb_dest, id_rs1, id_rs2, ex_dest;
    logic          mem_w, wb_w, u1, u2, ex_w, ex_ld, flush;
    logic [1:0]    exp_a, exp_b;
    logic          exp_stall, exp_bub;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    id_rs1 = '0; id_rs2 = '0; id_dest = '0; ex_rs1 = '0; ex_rs2 = '0; ex_dest = '0;
    mem_dest = '0; wb_dest = '0;
    id_rs1_used = 0; id_rs2_used = 0; id_reg_write = 0; id_is_mul = 0; branch_flush = 0;
    ex_reg_write = 0; ex_is_load = 0; mem_reg_write = 0; wb_reg_write = 0;
  endtask

  // Reference model helpers, derived from the architectural rules.
  function automatic logic m_eq(input logic [AW-1:0] a, input logic [AW-1:0] b);
`ifdef HAZARD_ZERO_REG_EN
    return (a == b) && (a != 0);
`else
    return a == b;
`endif
  endfunction

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
    if (mem_reg_write && m_eq(mem_dest, rs)) return 2'b01;
    if (wb_reg_write && m_eq(wb_dest, rs))   return 2'b10;
    return 2'b00;
  endfunction

  // Multiplier timeline: issue at cycle c -> busy for c+1..c+L-1, done at c+L.
  int            cyc;
  int            done_at;
  bit            active;
  logic [AW-1:0] m_pend;

  initial begin
    logic          e_busy, e_done, e_ld, e_sb, e_stall;
    logic [AW-1:0] zero_dest;
    rst = 1'b1;
    drive_idle();

    vecs[0] = '{ex_rs1:3, ex_rs2:1, mem_dest:3, wb_dest:3, id_rs1:0, id_rs2:0, ex_dest:0,
                mem_w:1, wb_w:1, u1:0, u2:0, ex_w:0, ex_ld:0, flush:0,
                exp_a:2'b01, exp_b:2'b00, exp_stall:0, exp_bub:0};
    vecs[1] = '{ex_rs1:3, ex_rs2:1, mem_dest:3, wb_dest:3, id_rs1:0, id_rs2:0, ex_dest:0,
                mem_w:0, wb_w:1, u1:0, u2:0, ex_w:0, ex_ld:0, flush:0,
                exp_a:2'b10, exp_b:2'b00, exp_stall:0, exp_bub:0};
    vecs[2] = '{ex_rs1:6, ex_rs2:4, mem_dest:4, wb_dest:4, id_rs1:0, id_rs2:0, ex_dest:0,
                mem_w:1, wb_w:1, u1:0, u2:0, ex_w:0, ex_ld:0, flush:0,
                exp_a:2'b00, exp_b:2'b01, exp_stall:0, exp_bub:0};
    vecs[3] = '{ex_rs1:1, ex_rs2:1, mem_dest:7, wb_dest:7, id_rs1:1, id_rs2:2, ex_dest:2,
                mem_w:0, wb_w:0, u1:1, u2:1, ex_w:1, ex_ld:1, flush:0,
                exp_a:2'b00, exp_b:2'b00, exp_stall:1, exp_bub:1};
    vecs[4] = '{ex_rs1:1, ex_rs2:1, mem_dest:7, wb_dest:7, id_rs1:1, id_rs2:2, ex_dest:2,
                mem_w:0, wb_w:0, u1:1, u2:0, ex_w:1, ex_ld:1, flush:0,
                exp_a:2'b00, exp_b:2'b00, exp_stall:0, exp_bub:0};
    vecs[5] = '{ex_rs1:1, ex_rs2:1, mem_dest:7, wb_dest:7, id_rs1:2, id_rs2:2, ex_dest:2,
                mem_w:0, wb_w:0, u1:1, u2:1, ex_w:0, ex_ld:1, flush:0,
                exp_a:2'b00, exp_b:2'b00, exp_stall:0, exp_bub:0};
`ifdef HAZARD_ZERO_REG_EN
    vecs[6] = '{ex_rs1:0, ex_rs2:5, mem_dest:0, wb_dest:0, id_rs1:0, id_rs2:0, ex_dest:0,
                mem_w:1, wb_w:1, u1:1, u2:0, ex_w:1, ex_ld:1, flush:0,
                exp_a:2'b00, exp_b:2'b00, exp_stall:0, exp_bub:0};
`else
    vecs[6] = '{ex_rs1:0, ex_rs2:5, mem_dest:0, wb_dest:0, id_rs1:0, id_rs2:0, ex_dest:0,
                mem_w:1, wb_w:1, u1:1, u2:0, ex_w:1, ex_ld:1, flush:0,
                exp_a:2'b01, exp_b:2'b00, exp_stall:1, exp_bub:1};
`endif
    vecs[7] = '{ex_rs1:2, ex_rs2:3, mem_dest:3, wb_dest:2, id_rs1:0, id_rs2:0, ex_dest:0,
                mem_w:1, wb_w:1, u1:0, u2:0, ex_w:0, ex_ld:0, flush:1,
                exp_a:2'b10, exp_b:2'b01, exp_stall:0, exp_bub:1};

    // Reset state.
    #3;
    chk("rst_busy", mul_busy, 0);
    chk("rst_done", mul_done, 0);
    chk("rst_dest", mul_dest, 0);
    chk("rst_byp_a", id_byp_a, 0);
    chk("rst_byp_b", id_byp_b, 0);
    @(negedge clk); rst = 1'b0;

    // Vector table for combinational forwarding / load-use.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_idle();
      ex_rs1 = vecs[i].ex_rs1; ex_rs2 = vecs[i].ex_rs2;
      mem_dest = vecs[i].mem_dest; mem_reg_write = vecs[i].mem_w;
      wb_dest = vecs[i].wb_dest; wb_reg_write = vecs[i].wb_w;
      id_rs1 = vecs[i].id_rs1; id_rs2 = vecs[i].id_rs2;
      id_rs1_used = vecs[i].u1; id_rs2_used = vecs[i].u2;
      ex_dest = vecs[i].ex_dest; ex_reg_write = vecs[i].ex_w; ex_is_load = vecs[i].ex_ld;
      branch_flush = vecs[i].flush;
      #1;
      chk($sformatf("vec%0d_fwd_a", i), fwd_a_sel, vecs[i].exp_a);
      chk($sformatf("vec%0d_fwd_b", i), fwd_b_sel, vecs[i].exp_b);
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      chk($sformatf("vec%0d_bubble", i), id_ex_bubble, vecs[i].exp_bub);
    end

    // Load-use: one stall cycle, then the load sits in EX/MEM and forwards.
    @(negedge clk); drive_idle();
    ex_dest = 2; ex_reg_write = 1; ex_is_load = 1; id_rs2 = 2; id_rs2_used = 1;
    #1; chk("lu_stall1", stall, 1); chk("lu_bub1", id_ex_bubble, 1);
    @(negedge clk); drive_idle();
    mem_dest = 2; mem_reg_write = 1; ex_rs2 = 2;
    #1; chk("lu_stall2", stall, 0); chk("lu_bub2", id_ex_bubble, 0); chk("lu_fwd_b", fwd_b_sel, 2'b01);

    // Multiply to r5, dependent read of r5.
    @(negedge clk); drive_idle();
    id_is_mul = 1; id_dest = 5; id_reg_write = 1;
    #1; chk("mul_c0_stall", stall, 0); chk("mul_c0_busy", mul_busy, 0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); drive_idle();
      id_rs1 = 5; id_rs1_used = 1; id_dest = 6; id_reg_write = 1;
      #1;
      chk($sformatf("mul_c%0d_busy", c), mul_busy, 1);
      chk($sformatf("mul_c%0d_stall", c), stall, 1);
      chk($sformatf("mul_c%0d_done", c), mul_done, 0);
      chk($sformatf("mul_c%0d_dest", c), mul_dest, 5);
    end
    @(negedge clk);
    #1; chk("mul_c3_done", mul_done, 1); chk("mul_c3_stall", stall, 0);
    chk("mul_c3_busy", mul_busy, 0); chk("mul_c3_byp_a", id_byp_a, 1); chk("mul_c3_byp_b", id_byp_b, 0);
    @(negedge clk); drive_idle();
    #1; chk("mul_c4_done", mul_done, 0);

    // Back-to-back multiplies: second is held until DONE, then chains into BUSY.
    @(negedge clk); drive_idle(); id_is_mul = 1; id_dest = 3; id_reg_write = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); drive_idle(); id_is_mul = 1; id_dest = 4; id_reg_write = 1;
      #1;
      chk($sformatf("b2b_c%0d_stall", c), stall, (c < 3) ? 1 : 0);
      chk($sformatf("b2b_c%0d_done", c), mul_done, (c == 3) ? 1 : 0);
    end
    @(negedge clk); drive_idle();
    #1; chk("b2b_c4_busy", mul_busy, 1); chk("b2b_c4_dest", mul_dest, 4);
    @(negedge clk); #1; chk("b2b_c5_busy", mul_busy, 1);
    @(negedge clk); #1; chk("b2b_c6_done", mul_done, 1);
    @(negedge clk); #1; chk("b2b_c7_idle", mul_busy | mul_done, 0);

    // Reset during BUSY aborts with no done pulse.
    @(negedge clk); drive_idle(); id_is_mul = 1; id_dest = 1; id_reg_write = 1;
    @(negedge clk); drive_idle();
    #1; chk("rstb_busy_pre", mul_busy, 1);
    rst = 1'b1;
    #1; chk("rstb_busy_now", mul_busy, 0); chk("rstb_dest", mul_dest, 0);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk($sformatf("rstb_nodone%0d", c), mul_done, 0);
      chk($sformatf("rstb_nobusy%0d", c), mul_busy, 0);
    end

    // Randomized cycles vs timeline model (starts from reset).
    @(negedge clk); drive_idle(); rst = 1'b1;
    active = 0; m_pend = '0; cyc = 0; done_at = 0;
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 59) == 0);
      id_rs1 = AW'($urandom_range(0, 7)); id_rs2 = AW'($urandom_range(0, 7));
      id_dest = AW'($urandom_range(0, 7)); ex_rs1 = AW'($urandom_range(0, 7));
      ex_rs2 = AW'($urandom_range(0, 7)); ex_dest = AW'($urandom_range(0, 7));
      mem_dest = AW'($urandom_range(0, 7)); wb_dest = AW'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom); id_reg_write = 1'($urandom);
      id_is_mul = ($urandom_range(0, 2) == 0); branch_flush = ($urandom_range(0, 5) == 0);
      ex_reg_write = 1'($urandom); ex_is_load = 1'($urandom);
      mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
      if (rst) begin active = 0; m_pend = '0; end
      #1;
      e_busy  = active && (cyc < done_at);
      e_done  = active && (cyc == done_at);
      e_ld    = ex_is_load && ex_reg_write &&
                ((id_rs1_used && m_eq(ex_dest, id_rs1)) || (id_rs2_used && m_eq(ex_dest, id_rs2)));
      e_sb    = e_busy && ((id_rs1_used && m_eq(id_rs1, m_pend)) ||
                           (id_rs2_used && m_eq(id_rs2, m_pend)) ||
                           (id_reg_write && m_eq(id_dest, m_pend)) || id_is_mul);
      e_stall = e_ld || e_sb;
      chk("rnd_fwd_a", fwd_a_sel, m_fwd(ex_rs1));
      chk("rnd_fwd_b", fwd_b_sel, m_fwd(ex_rs2));
      chk("rnd_stall", stall, e_stall);
      chk("rnd_bubble", id_ex_bubble, e_stall || branch_flush);
      chk("rnd_busy", mul_busy, e_busy);
      chk("rnd_done", mul_done, e_done);
      chk("rnd_dest", mul_dest, m_pend);
      chk("rnd_byp_a", id_byp_a, e_done && id_rs1_used && m_eq(id_rs1, m_pend));
      chk("rnd_byp_b", id_byp_b, e_done && id_rs2_used && m_eq(id_rs2, m_pend));
      zero_dest = id_dest;
      if (!rst && !e_busy && id_is_mul && !e_stall && !branch_flush) begin
        active = 1; done_at = cyc + L; m_pend = zero_dest;
      end
      cyc++;
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
